// File: rtl/pc_fetch_unit_if.sv
// Bundle between the PC stage and the rest of the core: PC-source select in,
// fetch address, mode and interrupt status out.
interface pc_fetch_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic [31:0]      next_pc;
  logic [2:0]       pcsrc;
  logic             irq_in;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             kernel;
  logic             irq_req;
  logic             irq_taken;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall, next_pc, pcsrc, irq_in,
    input  pc, pc_plus4, kernel, irq_req, irq_taken, retired
  );

  modport slave (
    input  stall, next_pc, pcsrc, irq_in,
    output pc, pc_plus4, kernel, irq_req, irq_taken, retired
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register with supervisor bit in pc[31], external
// interrupt synchronizer/pending latch, and a retired-instruction counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);

  logic [31:0]            pc_q, pc_d, pc_plus4;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   irq_edge;
  logic                   pending_q, pending_d;
  logic                   irq_req;
  logic                   take;
  logic                   taken_q;
  logic [CNT_W-1:0]       retired_q, retired_d;

  // Increment covers bits [30:0] only so the mode bit never carries.
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irq_edge = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign irq_req  = pending_q & ~pc_q[31];
  assign take     = ~bus.stall & (bus.pcsrc == 3'd4) & irq_req;

  always_comb begin
    pc_d = pc_q;
    if (!bus.stall) begin
      unique case (bus.pcsrc)
        3'd0, 3'd1, 3'd2: pc_d = {pc_q[31], bus.next_pc[30:0]};
        // Kernel may drop to user through jr; user can never raise itself.
        3'd3:             pc_d = {pc_q[31] & bus.next_pc[31], bus.next_pc[30:0]};
        3'd4, 3'd5:       pc_d = {1'b1, bus.next_pc[30:0]};
        default:          pc_d = pc_plus4;
      endcase
    end
  end

  always_comb begin
    // A fresh edge in the same cycle as a take must not be lost.
    pending_d = irq_edge | (pending_q & ~take);
    retired_d = bus.stall ? retired_q : retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      taken_q     <= 1'b0;
      retired_q   <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      pending_q   <= pending_d;
      taken_q     <= take;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.kernel    = pc_q[31];
  assign bus.irq_req   = irq_req;
  assign bus.irq_taken = taken_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized bench for pc_fetch_unit against a cycle-level
// behavioural model of the PC, mode, interrupt and counter rules.
module tb_pc_fetch_unit;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  pc_fetch_unit_if #(.CNT_W(32)) bus ();

  pc_fetch_unit #(
    .RESET_PC   (32'h8000_0000),
    .SYNC_STAGES(SYNC),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_pending;
  logic        m_taken;
  logic        m_last;
  int          edge_n = 0;
  int          due[$];  // edge numbers at which a captured irq edge becomes pending

  function automatic logic [31:0] plus4(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] next_rule(input logic [31:0] p, input logic [2:0] src,
                                            input logic [31:0] npc);
    logic [31:0] mode;
    mode = p & 32'h8000_0000;
    case (src)
      3'd0, 3'd1, 3'd2: return mode | (npc & 32'h7FFF_FFFF);
      3'd3:             return (npc & mode) | (npc & 32'h7FFF_FFFF);
      3'd4, 3'd5:       return npc | 32'h8000_0000;
      default:          return plus4(p);
    endcase
  endfunction

  task automatic model_reset();
    m_pc      = 32'h8000_0000;
    m_retired = 32'd0;
    m_pending = 1'b0;
    m_taken   = 1'b0;
    m_last    = 1'b0;
    due.delete();
  endtask

  task automatic model_edge();
    logic set, tk;
    edge_n++;
    set = 1'b0;
    while (due.size() > 0 && due[0] <= edge_n) begin
      set = 1'b1;
      void'(due.pop_front());
    end
    // A rising level seen at this edge reaches pending SYNC edges later.
    if (bus.irq_in && !m_last) due.push_back(edge_n + SYNC);
    m_last = bus.irq_in;
    tk = !bus.stall && bus.pcsrc == 3'd4 && m_pending && !m_pc[31];
    if (!bus.stall) begin
      m_pc      = next_rule(m_pc, bus.pcsrc, bus.next_pc);
      m_retired = m_retired + 32'd1;
    end
    m_pending = set || (m_pending && !tk);
    m_taken   = tk;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, plus4(m_pc));
    chk("kernel", {31'b0, bus.kernel}, {31'b0, m_pc[31]});
    chk("irq_req", {31'b0, bus.irq_req}, {31'b0, m_pending & ~m_pc[31]});
    chk("irq_taken", {31'b0, bus.irq_taken}, {31'b0, m_taken});
    chk("retired", bus.retired, m_retired);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic st, input logic [2:0] src, input logic [31:0] npc);
    bus.stall   = st;
    bus.pcsrc   = src;
    bus.next_pc = npc;
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ret_hold;
    reset      = 1'b1;
    bus.irq_in = 1'b0;
    drive(1'b0, 3'd0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pc", bus.pc, 32'h8000_0000);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch from reset
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, plus4(m_pc));
      step();
    end
    chk("seq3_pc", bus.pc, 32'h8000_000C);
    chk("seq3_retired", bus.retired, 32'd3);

    // Reset asserted mid-cycle from a user-mode PC
    drive(1'b0, 3'd3, 32'h0000_0040);
    step();
    chk("jr_0x40", bus.pc, 32'h0000_0040);
    mid_reset();
    chk("midreset_pc", bus.pc, 32'h8000_0000);
    chk("midreset_retired", bus.retired, 32'd0);

    // Mode protection
    drive(1'b0, 3'd3, 32'h0000_0100);
    step();
    drive(1'b0, 3'd3, 32'h8000_0200);
    step();
    chk("user_jr_stays_user", bus.pc, 32'h0000_0200);
    drive(1'b0, 3'd5, 32'h0000_0010);
    step();
    chk("xadr_forces_kernel", bus.pc, 32'h8000_0010);
    drive(1'b0, 3'd3, 32'h0000_0400);
    step();
    chk("kernel_jr_to_user", bus.pc, 32'h0000_0400);
    chk("kernel_cleared", {31'b0, bus.kernel}, 32'd0);

    // Interrupt in user mode
    drive(1'b0, 3'd2, 32'h0000_0020);
    step();
    bus.irq_in = 1'b1;
    step();
    step();
    chk("irq_req_early", {31'b0, bus.irq_req}, 32'd0);
    step();
    chk("irq_req_latency", {31'b0, bus.irq_req}, 32'd1);
    drive(1'b0, 3'd4, 32'h8000_0004);
    step();
    chk("irq_vector", bus.pc, 32'h8000_0004);
    chk("irq_taken_pulse", {31'b0, bus.irq_taken}, 32'd1);
    bus.irq_in = 1'b0;
    drive(1'b0, 3'd2, 32'h8000_0030);
    step();
    chk("irq_taken_drop", {31'b0, bus.irq_taken}, 32'd0);
    drive(1'b0, 3'd3, 32'h0000_0060);
    step();
    chk("pending_cleared", {31'b0, bus.irq_req}, 32'd0);
    drive(1'b0, 3'd5, 32'h8000_0030);
    step();

    // Interrupt edge while in kernel mode stays pending
    bus.irq_in = 1'b1;
    drive(1'b0, 3'd2, 32'h8000_0030);
    repeat (4) step();
    chk("kernel_masks_irq", {31'b0, bus.irq_req}, 32'd0);
    drive(1'b0, 3'd3, 32'h0000_0050);
    step();
    chk("irq_after_return", {31'b0, bus.irq_req}, 32'd1);

    // Stall with a takeable interrupt: nothing moves
    bus.irq_in = 1'b0;
    ret_hold   = m_retired;
    drive(1'b1, 3'd4, 32'h8000_0100);
    repeat (4) step();
    chk("stall_pc", bus.pc, 32'h0000_0050);
    chk("stall_retired", bus.retired, ret_hold);
    chk("stall_pending", {31'b0, bus.irq_req}, 32'd1);
    drive(1'b0, 3'd4, 32'h8000_0100);
    step();
    chk("take_after_stall", {31'b0, bus.irq_taken}, 32'd1);

    // Irq edge arriving during a stall survives it
    drive(1'b0, 3'd3, 32'h0000_0070);
    step();
    drive(1'b1, 3'd4, 32'h8000_0100);
    step();
    bus.irq_in = 1'b1;
    repeat (4) step();
    drive(1'b0, 3'd2, 32'h0000_0074);
    step();
    chk("stall_edge_pending", {31'b0, bus.irq_req}, 32'd1);

    // Wrap-around of the 31-bit address field
    drive(1'b0, 3'd3, 32'h7FFF_FFFC);
    step();
    drive(1'b0, 3'd0, plus4(m_pc));
    step();
    chk("wrap_user", bus.pc, 32'h0000_0000);
    drive(1'b0, 3'd5, 32'h7FFF_FFFC);
    step();
    chk("wrap_kernel_plus4", bus.pc_plus4, 32'h8000_0000);
    drive(1'b0, 3'd6, 32'h1234_5678);
    step();
    chk("illegal_src_wrap", bus.pc, 32'h8000_0000);

    // New edge landing on the take edge keeps pending set
    bus.irq_in = 1'b0;
    drive(1'b0, 3'd3, 32'h0000_0100);
    step();
    drive(1'b0, 3'd2, 32'h0000_0100);
    repeat (3) step();
    bus.irq_in = 1'b1;
    drive(1'b1, 3'd2, 32'h0000_0100);
    step();
    step();
    drive(1'b0, 3'd4, 32'h8000_0004);
    step();
    chk("collide_taken", {31'b0, bus.irq_taken}, 32'd1);
    drive(1'b0, 3'd3, 32'h0000_0200);
    step();
    chk("collide_pending", {31'b0, bus.irq_req}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom);
        if ($urandom_range(0, 5) == 0) bus.irq_in = ~bus.irq_in;
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-period MIPS core.
- Registers the next-PC value chosen by the PC-source mux and drives `pc` and `pc_plus4` to instruction memory, the branch adder and the write-back mux.
- Owns supervisor mode, held in PC[31].
- Owns external-interrupt capture: synchronizer, pending latch and request to the control unit.
- Keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset (kernel mode).
- SYNC_STAGES, 2, flip-flop depth of the irq_in synchronizer (minimum 2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and counter this cycle (memory not ready).
- next_pc  in  32  target selected by the PC-source mux.
- pcsrc  in  3  PC-source select: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 ILLOP/IRQ, 5 XADR.
- irq_in  in  1  external interrupt, asynchronous, level; rising edge is significant.
- pc  out  32  current instruction address.
- pc_plus4  out  32  {pc[31], pc[30:0]+4}.
- kernel  out  1  equals pc[31].
- irq_req  out  1  interrupt pending and takeable; the control unit forces pcsrc=4 when this is high.
- irq_taken  out  1  one-cycle pulse on the edge that loads the interrupt vector.
- retired  out  CNT_W  count of committed PC updates.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-interrupt):
  - pc=RESET_PC, synchronizer flops=0, pending=0, irq_taken=0, retired=0.
  - Outputs are valid combinationally from these values.
- Synchronizer: SYNC_STAGES flops on irq_in. edge = sync_last & ~sync_prev. Synchronizer runs even when stall=1.
- Pending latch:
  - Set on edge; cleared on a non-stalled clock with pcsrc==4 and irq_req==1.
  - If set and clear occur in the same cycle, set wins (the new interrupt is not lost).
  - Pending is not cleared when stall=1.
- irq_req = pending & ~pc[31]. Interrupts are never taken in kernel mode; they stay pending until return to user mode.
- PC update happens on each rising clk with stall=0. PC holds when stall=1.
- Next-PC bit rules:
  - pcsrc 0, 1 or 2: pc <= {pc[31], next_pc[30:0]}. Mode is preserved, so branches and jumps cannot change mode.
  - pcsrc 3: pc <= {pc[31] & next_pc[31], next_pc[30:0]}. Kernel may return to user; user cannot enter kernel.
  - pcsrc 4 or 5: pc <= next_pc, and the low 31 bits are taken as-is.
  - pcsrc 4 with pc[31]==0 and pending==1 marks the interrupt as taken.
  - pcsrc 6 or 7 (illegal encodings): pc <= {pc[31], pc[30:0]+4}.
  - Bit 31 is forced to 1 for pcsrc 4/5 regardless of next_pc[31].
- irq_taken registers to 1 for exactly the cycle after a taken interrupt; otherwise 0.
- Wrap-around:
  - pc_plus4 is computed on bits [30:0] only. 0x7FFF_FFFC gives 0x0000_0000; 0xFFFF_FFFC gives 0x8000_0000.
  - retired wraps modulo 2^CNT_W.
- retired increments by 1 on every non-stalled clock after reset release, and holds on stall.
- Latency:
  - next_pc to pc is 1 cycle.
  - irq_in edge to irq_req is SYNC_STAGES+1 cycles, when in user mode.
- Alignment: pc[1:0] is loaded as given. Alignment checking belongs to the control unit.

Test Plan:
- Reset: assert reset mid-cycle with pc=0x0000_0040 -> pc=0x8000_0000 immediately, retired=0, irq_req=0; release, 3 clocks with pcsrc=0 and next_pc=pc_plus4 -> pc=0x8000_000C, retired=3.
- Mode protection:
  - From pc=0x0000_0100, pcsrc=3, next_pc=0x8000_0200 -> pc=0x0000_0200.
  - From pc=0x8000_0010, pcsrc=3, next_pc=0x0000_0400 -> pc=0x0000_0400, kernel=0.
- Interrupt in user mode: pc=0x0000_0020, pulse irq_in -> irq_req high after 3 clocks; control drives pcsrc=4, next_pc=0x8000_0004 -> pc=0x8000_0004, irq_taken pulses 1 cycle, pending clears.
- Interrupt in kernel: irq edge while pc=0x8000_0030 -> irq_req stays 0; jr to 0x0000_0050 -> irq_req=1 on the next cycle.
- Stall: stall=1 for 4 clocks with pcsrc=4 and pending set -> pc, retired and pending unchanged; an irq edge during the stall is still pending after the stall releases.
- Wrap and collision:
  - pc=0x7FFF_FFFC, pcsrc=0 -> pc=0x0000_0000.
  - New irq edge in the same cycle as a take -> pending remains 1 after the take.
